// File: rtl/adc_channel_filter.sv
// adc_channel_filter
//   Box-car averager and hysteresis line detector placed after adc_control.
//   Every change of data_frame snapshots the three channel results into
//   per-channel accumulators. After 2^AVG_LOG2 snapshots the averages are
//   published for one cycle with avg_valid, and the per-channel line bits are
//   re-evaluated against THR_HI / THR_LO with hysteresis.
//
// Ports
//   clk_50      in   1   system clock, rising edge
//   rst         in   1   synchronous reset, active-high
//   data_frame  in   2   frame indicator; any value change is a snapshot point
//   d_out_ch5   in  12   channel 5 conversion result
//   d_out_ch6   in  12   channel 6 conversion result
//   d_out_ch7   in  12   channel 7 conversion result
//   avg_ch5     out 12   channel 5 windowed average
//   avg_ch6     out 12   channel 6 windowed average
//   avg_ch7     out 12   channel 7 windowed average
//   line_bits   out  3   {ch7, ch6, ch5} hysteresis line-detect flags
//   avg_valid   out  1   one-cycle pulse when avg_* / line_bits update
module adc_channel_filter #(
  parameter int AVG_LOG2 = 2,
  parameter int THR_HI   = 2000,
  parameter int THR_LO   = 1500
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [1:0]  data_frame,
  input  logic [11:0] d_out_ch5,
  input  logic [11:0] d_out_ch6,
  input  logic [11:0] d_out_ch7,
  output logic [11:0] avg_ch5,
  output logic [11:0] avg_ch6,
  output logic [11:0] avg_ch7,
  output logic [2:0]  line_bits,
  output logic        avg_valid
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int N     = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [11:0]      THR_HI_C = 12'(THR_HI);
  localparam logic [11:0]      THR_LO_C = 12'(THR_LO);

  typedef enum logic {ACCUM, EMIT} state_t;

  // Hysteresis: set at or above the high threshold, clear at or below the
  // low threshold, keep the previous decision in the band between.
  function automatic logic hyst(input logic [11:0] avg, input logic prev);
    if (avg >= THR_HI_C)      return 1'b1;
    else if (avg <= THR_LO_C) return 1'b0;
    else                      return prev;
  endfunction

  logic [11:0] d_in [3];
  assign d_in[0] = d_out_ch5;
  assign d_in[1] = d_out_ch6;
  assign d_in[2] = d_out_ch7;

  state_t           state_q, state_d;
  logic [1:0]       prev_frame_q;
  logic [ACC_W-1:0] acc_q [3];
  logic [ACC_W-1:0] acc_d [3];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      avg_q [3];
  logic [11:0]      avg_d [3];
  logic [2:0]       line_q, line_d;
  logic             valid_q, valid_d;
  logic             frame_edge;

  assign frame_edge = (data_frame != prev_frame_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    valid_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_d[i] = acc_q[i];
      avg_d[i] = avg_q[i];
    end

    if (state_q == ACCUM) begin
      if (frame_edge) begin
        for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i] + ACC_W'(d_in[i]);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = EMIT;
      end
    end else begin
      // The accumulators already hold the full window here; the shift is a
      // plain truncating divide by N.
      for (int i = 0; i < 3; i++) begin
        avg_d[i]  = acc_q[i][ACC_W-1:AVG_LOG2];
        line_d[i] = hyst(avg_d[i], line_q[i]);
      end
      valid_d = 1'b1;
      state_d = ACCUM;
      // A snapshot landing in the publish cycle seeds the next window.
      if (frame_edge) begin
        for (int i = 0; i < 3; i++) acc_d[i] = ACC_W'(d_in[i]);
        cnt_d = CNT_W'(1);
      end else begin
        for (int i = 0; i < 3; i++) acc_d[i] = '0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q      <= ACCUM;
      prev_frame_q <= 2'b00;
      cnt_q        <= '0;
      line_q       <= 3'b000;
      valid_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        avg_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      prev_frame_q <= data_frame;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
        avg_q[i] <= avg_d[i];
      end
    end
  end

  assign avg_ch5   = avg_q[0];
  assign avg_ch6   = avg_q[1];
  assign avg_ch7   = avg_q[2];
  assign line_bits = line_q;
  assign avg_valid = valid_q;

endmodule

// File: tb/tb_adc_channel_filter.sv
// Testbench for adc_channel_filter: table of averaging windows plus
// hand-written sequences for the publish-cycle snapshot and mid-window reset.
// Expected pulses are queued when the last snapshot of a window is driven and
// checked when avg_valid appears.
module tb_adc_channel_filter;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [1:0]  data_frame;
  logic [11:0] d_out_ch5, d_out_ch6, d_out_ch7;
  logic [11:0] avg_ch5, avg_ch6, avg_ch7;
  logic [2:0]  line_bits;
  logic        avg_valid;

  always #10 clk_50 = ~clk_50;

  adc_channel_filter #(.AVG_LOG2(2), .THR_HI(2000), .THR_LO(1500)) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .data_frame (data_frame),
    .d_out_ch5  (d_out_ch5),
    .d_out_ch6  (d_out_ch6),
    .d_out_ch7  (d_out_ch7),
    .avg_ch5    (avg_ch5),
    .avg_ch6    (avg_ch6),
    .avg_ch7    (avg_ch7),
    .line_bits  (line_bits),
    .avg_valid  (avg_valid)
  );

  typedef struct {
    logic [3:0][11:0] c5, c6, c7;
    logic [11:0]      e5, e6, e7;
    logic [2:0]       el;
    int               gap;
  } win_t;

  typedef struct {
    logic [11:0] e5, e6, e7;
    logic [2:0]  el;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  win_t       wt[5];
  int         errors = 0;
  int         checks = 0;
  int         npulse = 0;
  int         cyc = 0;
  logic [1:0] fr = 2'b00;
  logic       prev_v = 1'b0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every avg_valid pulse is matched against the queue.
  always @(negedge clk_50) begin
    exp_t r;
    if (avg_valid) begin
      npulse++;
      chk("single_cycle_pulse", int'(prev_v), 0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        r = sbq.pop_front();
        chk("pulse_cycle", cyc, r.cyc);
        chk("avg_ch5", avg_ch5, r.e5);
        chk("avg_ch6", avg_ch6, r.e6);
        chk("avg_ch7", avg_ch7, r.e7);
        chk("line_bits", line_bits, r.el);
      end
    end
    prev_v = avg_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  // Change data_frame with new channel values; the DUT samples them at the
  // following rising edge. When push is set that edge completes a window and
  // the pulse is due one cycle later.
  task automatic snap(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                      input bit push, input logic [11:0] e5, input logic [11:0] e6,
                      input logic [11:0] e7, input logic [2:0] el);
    exp_t r;
    @(negedge clk_50);
    fr         = fr + 2'd1;
    data_frame = fr;
    d_out_ch5  = a;
    d_out_ch6  = b;
    d_out_ch7  = c;
    @(posedge clk_50);
    #1;
    if (push) begin
      r.e5 = e5; r.e6 = e6; r.e7 = e7; r.el = el; r.cyc = cyc + 1;
      sbq.push_back(r);
    end
  endtask

  initial begin
    // Windows: inputs, expected truncated averages, expected line bits.
    wt[0].c5 = {4{12'd1118}}; wt[0].c6 = {4{12'd1998}}; wt[0].c7 = {4{12'd3802}};
    wt[0].e5 = 1118; wt[0].e6 = 1998; wt[0].e7 = 3802; wt[0].el = 3'b100; wt[0].gap = 320;
    wt[1].c5 = {12'd1, 12'd2, 12'd2, 12'd2}; wt[1].c6 = {4{12'd2100}}; wt[1].c7 = {4{12'd0}};
    wt[1].e5 = 1; wt[1].e6 = 2100; wt[1].e7 = 0; wt[1].el = 3'b010; wt[1].gap = 4;
    wt[2].c5 = {4{12'd4095}}; wt[2].c6 = {4{12'd1800}}; wt[2].c7 = {4{12'd1500}};
    wt[2].e5 = 4095; wt[2].e6 = 1800; wt[2].e7 = 1500; wt[2].el = 3'b011; wt[2].gap = 4;
    wt[3].c5 = {12'd1501, 12'd1999, 12'd1600, 12'd1700}; wt[3].c6 = {4{12'd1400}};
    wt[3].c7 = {12'd2000, 12'd2000, 12'd2001, 12'd2002};
    wt[3].e5 = 1700; wt[3].e6 = 1400; wt[3].e7 = 2000; wt[3].el = 3'b101; wt[3].gap = 4;
    wt[4].c5 = {12'd1503, 12'd1500, 12'd1500, 12'd1500}; wt[4].c6 = {12'd3, 12'd0, 12'd0, 12'd0};
    wt[4].c7 = {4{12'd1999}};
    wt[4].e5 = 1500; wt[4].e6 = 0; wt[4].e7 = 1999; wt[4].el = 3'b100; wt[4].gap = 4;

    // Reset with a static frame indicator.
    rst = 1'b1; data_frame = 2'b00; d_out_ch5 = '0; d_out_ch6 = '0; d_out_ch7 = '0;
    idle(3);
    rst = 1'b0;
    chk("reset_avg_ch5", avg_ch5, 0);
    chk("reset_avg_ch6", avg_ch6, 0);
    chk("reset_avg_ch7", avg_ch7, 0);
    chk("reset_line_bits", line_bits, 0);
    chk("reset_avg_valid", avg_valid, 0);
    idle(100);
    chk("static_frame_no_pulse", npulse, 0);

    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 4; j++) begin
        snap(wt[w].c5[j], wt[w].c6[j], wt[w].c7[j], j == 3,
             wt[w].e5, wt[w].e6, wt[w].e7, wt[w].el);
        idle(wt[w].gap);
      end
    end
    chk("table_pulse_count", npulse, 5);

    // Snapshot during the publish cycle seeds the next window.
    snap(12'd100, 12'd1000, 12'd3000, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd200, 12'd1000, 12'd3000, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd300, 12'd1000, 12'd3000, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd400, 12'd1000, 12'd3000, 1'b1, 12'd250, 12'd1000, 12'd3000, 3'b100);
    snap(12'd800, 12'd2500, 12'd40, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd800, 12'd2500, 12'd40, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd800, 12'd2500, 12'd40, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd800, 12'd2500, 12'd40, 1'b1, 12'd800, 12'd2500, 12'd40, 3'b010);
    idle(10);
    chk("emit_edge_pulse_count", npulse, 7);

    // Mid-window reset discards the partial sum.
    snap(12'd4000, 12'd4000, 12'd4000, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd4000, 12'd4000, 12'd4000, 1'b0, 0, 0, 0, 0); idle(3);
    @(negedge clk_50);
    rst = 1'b1; fr = 2'b00; data_frame = 2'b00;
    @(negedge clk_50);
    rst = 1'b0;
    chk("midreset_avg_ch5", avg_ch5, 0);
    chk("midreset_line_bits", line_bits, 0);
    idle(20);
    snap(12'd10, 12'd2000, 12'd1600, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd20, 12'd2000, 12'd1600, 1'b0, 0, 0, 0, 0); idle(3);
    snap(12'd30, 12'd2000, 12'd1600, 1'b0, 0, 0, 0, 0); idle(30);
    chk("three_edges_no_pulse", npulse, 7);
    snap(12'd40, 12'd2000, 12'd1600, 1'b1, 12'd25, 12'd2000, 12'd1600, 3'b010);
    idle(20);

    chk("total_pulse_count", npulse, 8);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
